ahbl_to_apb3_bridge: RTL
========================

Name: ahbl_to_apb3_bridge

Overview:
- AHB-Lite slave to APB3 master bridge. Sits directly downstream of the AXI-to-AHB-Lite bridge on the HCLK domain.
- Converts each single AHB-Lite transfer into one APB3 SETUP/ACCESS transfer. Stretches the AHB data phase with HREADYOUT wait states until PREADY.
- Maps PSLVERR, APB timeout and unsupported AHB requests onto the AHB two-cycle ERROR response.

Parameters:
- PADDR_WIDTH, 32, width of PADDR; equals HADDR[PADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before a forced error; 0 disables the timeout.

Ports:
- HCLK  in  1  single clock for the AHB and APB sides.
- HRESET  in  1  reset, asynchronous, active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  ignored; every beat is handled as a single transfer.
- HWDATA  in  32  data-phase write data.
- HREADYIN  in  1  bus-wide HREADY.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  1 = ERROR.
- HRDATA  out  32  read data.
- PADDR  out  PADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Clocking and reset: one clock, HCLK. Reset HRESET is asynchronous, active-high.
- Reset values: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, timeout count=0. All outputs are registered.
- Valid transfer: HSEL & HTRANS[1] & HREADYIN sampled high on a rising edge in IDLE or ERR2 (cycle N). HADDR, HWRITE and HSIZE are latched at that edge.
- IDLE or BUSY transfers, or HSEL=0: no response beyond HREADYOUT=1 and HRESP=0 (zero-wait OKAY).
- Unsupported request: HSIZE>2, HSIZE=2 with HADDR[1:0]!=0, or HSIZE=1 with HADDR[0]!=0. No APB access; state goes directly to ERR1.
- States:
  - IDLE: HREADYOUT=1.
  - WDATA (writes only, N+1): HREADYOUT=0. HWDATA is registered into PWDATA at the end of this cycle.
  - SETUP: PSEL=1, PENABLE=0. Entered at N+1 for reads, N+2 for writes.
  - ACCESS: PSEL=1, PENABLE=1.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - IDLE to WDATA or SETUP on a valid transfer.
  - WDATA to SETUP.
  - SETUP to ACCESS always.
  - ACCESS & PREADY & !PSLVERR: HRDATA<=PRDATA (reads; held otherwise). Next state IDLE with PSEL=0 and HREADYOUT=1, so the data phase completes at that cycle.
  - ACCESS & PREADY & PSLVERR: ERR1, PSEL=0.
  - ACCESS & !PREADY: stay. Count increments from 0 on ACCESS entry. If TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES-1 without PREADY: PSEL=0, PENABLE=0, go ERR1.
  - ERR1 to ERR2.
  - ERR2 to IDLE, or to WDATA/SETUP if a valid transfer is sampled in ERR2.
- Latency, zero-wait APB slave: read data phase = 3 cycles (HREADYOUT low 2 cycles); write data phase = 4 cycles.
- Back-to-back: an address phase presented in the completion cycle (IDLE, HREADYIN=1) is accepted. There is no idle APB cycle between PSEL deassert and the next SETUP beyond the state sequence.
- PADDR and PWRITE are stable from SETUP through the end of ACCESS.
- PWDATA is stable from SETUP through the end of ACCESS and keeps its value afterwards.
- While HREADYOUT=0, HSEL/HTRANS are not sampled.
- A reset asserted mid-transfer drops PSEL and PENABLE immediately (asynchronously). No completion is signalled.

Decomposition:
- Shared package bridge_pkg holds:
  - HTRANS encodings.
  - State enum with values IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
  - HRESP_OKAY and HRESP_ERROR constants.
- One sub-module, apb_timeout_ctr: loadable counter with enable, clear and expired output, sized from TIMEOUT_CYCLES.
- FSM and datapath stay in the top module.

Test Plan:
- Read: NONSEQ read HADDR=0x4000_0010, HSIZE=2, PREADY=1, PRDATA=0xCAFE_F00D -> PADDR=0x4000_0010 with PSEL at N+1, PENABLE at N+2; HREADYOUT=1 and HRDATA=0xCAFE_F00D at N+3; HRESP=0.
- Write with slow slave: NONSEQ write, HWDATA=0x1234_5678, PREADY held low 3 ACCESS cycles -> PWDATA=0x1234_5678 from SETUP onward; PSEL high 5 cycles; HREADYOUT low until the cycle after PREADY.
- PSLVERR: read with PREADY=1 and PSLVERR=1 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then OKAY.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck low -> PSEL drops after 4 ACCESS cycles; two-cycle ERROR follows.
- Unsupported and back-to-back:
  - HSIZE=2 with HADDR=0x2 -> no PSEL pulse and a two-cycle ERROR.
  - Write then read issued in consecutive address phases -> both APB transfers occur in order with correct data.
- Reset: HRESET asserted during ACCESS -> PSEL, PENABLE=0 and HREADYOUT=1 before the next clock edge. A subsequent read completes normally.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared encodings and state type for the AHB-Lite to APB3 bridge.
package bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_e;

  // Sizes above a word, or sizes not naturally aligned, cannot be mapped onto APB.
  function automatic logic size_unsupported(input logic [2:0] size, input logic [1:0] addr_lo);
    return (size > 3'd2) ||
           ((size == 3'd2) && (addr_lo != 2'b00)) ||
           ((size == 3'd1) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts stalled APB ACCESS cycles; flags when the last permitted cycle is reached.
module apb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  // A zero limit disables the timeout entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && (count_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ahbl_to_apb3_bridge.sv
// AHB-Lite slave to APB3 master bridge: one APB SETUP/ACCESS per AHB beat,
// with PSLVERR, timeouts and unsupported sizes reported as a two-cycle ERROR.
module ahbl_to_apb3_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [2:0]             HBURST,
  input  logic [31:0]            HWDATA,
  input  logic                   HREADYIN,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic [31:0]            HRDATA,
  output logic [PADDR_WIDTH-1:0] PADDR,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  input  logic [31:0]            PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  state_e state_q, state_d;

  logic                   hreadyout_q, hresp_q, psel_q, penable_q, pwrite_q;
  logic [PADDR_WIDTH-1:0] paddr_q;
  logic [31:0]            pwdata_q, hrdata_q;
  logic                   valid, accept, bad_req, expired;

  assign valid   = HSEL & HTRANS[1] & HREADYIN;
  assign accept  = valid && ((state_q == IDLE) || (state_q == ERR2));
  assign bad_req = size_unsupported(HSIZE, HADDR[1:0]);

  apb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (HCLK),
    .rst     (HRESET),
    .clr     (state_q != ACCESS),
    .en      ((state_q == ACCESS) && !PREADY),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERR2: begin
        if (valid) begin
          state_d = bad_req ? ERR1 : (HWRITE ? WDATA : SETUP);
        end else begin
          state_d = IDLE;
        end
      end
      WDATA:  state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_d = PSLVERR ? ERR1 : IDLE;
        end else if (expired) begin
          state_d = ERR1;
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= (state_d == IDLE) || (state_d == ERR2);
      hresp_q     <= ((state_d == ERR1) || (state_d == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q   <= (state_d == ACCESS);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (accept) begin
        paddr_q  <= HADDR[PADDR_WIDTH-1:0];
        pwrite_q <= HWRITE;
      end
      if (state_q == WDATA) begin
        pwdata_q <= HWDATA;
      end
      if ((state_q == ACCESS) && PREADY && !PSLVERR && !pwrite_q) begin
        hrdata_q <= PRDATA;
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

  logic unused_bits;
  assign unused_bits = ^{HBURST, HTRANS[0], HADDR};

endmodule
